// File: rtl/core_launch_sequencer.sv
// Launches four cores on consecutive cycles, collects their done signals, and
// reports the run status, elapsed cycle count and a timeout flag.
module core_launch_sequencer #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd5000,
    parameter int unsigned COUNT_W        = 16
) (
    input  logic               fast_clock,
    input  logic               reset_n,
    input  logic               start_process,
    input  logic [3:0]         core_done,
    output logic [3:0]         core_start,
    output logic [1:0]         status,
    output logic               timeout,
    output logic [COUNT_W-1:0] cycle_count
);
    localparam int unsigned CMP_W = (COUNT_W > 16) ? COUNT_W : 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LAUNCH   = 2'd1,
        RUNNING  = 2'd2,
        FINISHED = 2'd3
    } state_t;

    state_t             state, state_next;
    logic               start_q, start_prev, start_rise;
    logic [3:0]         launched, done_capt, done_mask, done_mask_next, core_start_next;
    logic               timeout_next, mask_full, count_hit;
    logic [COUNT_W-1:0] count_inc, count_next;

    assign start_rise = start_q & ~start_prev;
    assign status     = state;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge fast_clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            start_q     <= 1'b0;
            start_prev  <= 1'b0;
            core_start  <= 4'b0000;
            done_mask   <= 4'b0000;
            timeout     <= 1'b0;
            cycle_count <= '0;
        end else begin
            state       <= state_next;
            start_q     <= start_process;
            start_prev  <= start_q;
            core_start  <= core_start_next;
            done_mask   <= done_mask_next;
            timeout     <= timeout_next;
            cycle_count <= count_next;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        launched        = 4'b0000;
        state_next      = state;
        core_start_next = 4'b0000;
        timeout_next    = timeout;
        done_mask_next  = done_mask;
        count_next      = cycle_count;

        // core_start is one-hot during LAUNCH, so cores at or below the hot bit are launched
        case (state)
            LAUNCH:  launched = {core_start[3], |core_start[3:2], |core_start[3:1], 1'b1};
            RUNNING: launched = 4'b1111;
            default: launched = 4'b0000;
        endcase

        done_capt = done_mask | (core_done & launched);
        mask_full = &done_capt;
        count_inc = (&cycle_count) ? cycle_count : cycle_count + COUNT_W'(1);
        count_hit = CMP_W'(count_inc) >= CMP_W'(TIMEOUT_CYCLES);

        case (state)
            IDLE: begin
                if (start_rise) begin
                    state_next      = LAUNCH;
                    core_start_next = 4'b0001;
                    timeout_next    = 1'b0;
                    done_mask_next  = 4'b0000;
                    count_next      = '0;
                end
            end
            LAUNCH: begin
                done_mask_next = done_capt;
                count_next     = count_inc;
                if (count_hit && !mask_full) begin
                    state_next   = FINISHED;
                    timeout_next = 1'b1;
                end else if (core_start[3]) begin
                    state_next = RUNNING;
                end else begin
                    core_start_next = core_start << 1;
                end
            end
            RUNNING: begin
                done_mask_next = done_capt;
                count_next     = count_inc;
                // completion takes priority over a simultaneous timeout
                if (mask_full) begin
                    state_next = FINISHED;
                end else if (count_hit) begin
                    state_next   = FINISHED;
                    timeout_next = 1'b1;
                end
            end
            FINISHED: begin
                if (!start_process) state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_core_launch_sequencer.sv
// Self-checking bench for core_launch_sequencer: directed and randomized runs
// checked cycle by cycle against a done-schedule reference model.
module tb_core_launch_sequencer;
    localparam int T       = 20;
    localparam int SCHED_N = 32;

    logic        fast_clock, reset_n, start_process, start_sat;
    logic [3:0]  core_done, done_sat, core_start, cs_sat;
    logic [1:0]  status, status_sat;
    logic        timeout, timeout_sat;
    logic [15:0] cycle_count;
    logic [2:0]  count_sat;

    // sched[r] = core_done value driven during the r-th cycle after launch
    logic [3:0]  sched [SCHED_N];
    int          n_checks = 0;
    int          n_fail   = 0;

    core_launch_sequencer #(.TIMEOUT_CYCLES(16'd20), .COUNT_W(16)) dut (
        .fast_clock    (fast_clock),
        .reset_n       (reset_n),
        .start_process (start_process),
        .core_done     (core_done),
        .core_start    (core_start),
        .status        (status),
        .timeout       (timeout),
        .cycle_count   (cycle_count)
    );

    core_launch_sequencer #(.TIMEOUT_CYCLES(16'd5000), .COUNT_W(3)) dut_sat (
        .fast_clock    (fast_clock),
        .reset_n       (reset_n),
        .start_process (start_sat),
        .core_done     (done_sat),
        .core_start    (cs_sat),
        .status        (status_sat),
        .timeout       (timeout_sat),
        .cycle_count   (count_sat)
    );

    initial fast_clock = 1'b0;
    always #5 fast_clock = ~fast_clock;

    task automatic step();
        @(posedge fast_clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_sched();
        foreach (sched[r]) sched[r] = 4'b0000;
    endtask

    // Core i is launched at relative cycle i; its done counts from then on.
    // The run ends one cycle after the last capture, but never before relative
    // cycle 5 (one RUNNING cycle must follow the four launch cycles). If that
    // would be later than T active cycles (or a core never reports), it times
    // out after exactly T cycles.
    function automatic void model(output int fin, output bit to);
        int mx;
        int cap;
        bit complete;
        mx = 0;
        complete = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cap = -1;
            for (int r = i; r < SCHED_N; r++)
                if (cap < 0 && sched[r][i]) cap = r;
            if (cap < 0) complete = 1'b0;
            else if (cap > mx) mx = cap;
        end
        fin = (mx + 1 > 5) ? mx + 1 : 5;
        to  = !complete || fin > T;
        if (to) fin = T;
    endfunction

    task automatic do_run(input string name, input int toggle_at, input int hold_n, input int abort_at);
        int fin;
        bit to;
        model(fin, to);
        core_done     = 4'b0000;
        start_process = 1'b1;
        step();
        check($sformatf("%s.pre_status", name), status, 0);
        for (int r = 0; r <= fin; r++) begin
            step();
            check($sformatf("%s.status@%0d", name, r), status, (r == fin) ? 3 : ((r < 4) ? 1 : 2));
            check($sformatf("%s.core_start@%0d", name, r), core_start, (r < 4) ? (1 << r) : 0);
            check($sformatf("%s.count@%0d", name, r), cycle_count, r);
            check($sformatf("%s.timeout@%0d", name, r), timeout, (r == fin) ? to : 0);
            if (r == abort_at) begin
                core_done = 4'b0000;
                #2 reset_n = 1'b0;
                #1;
                check($sformatf("%s.rst_status", name), status, 0);
                check($sformatf("%s.rst_core_start", name), core_start, 0);
                check($sformatf("%s.rst_count", name), cycle_count, 0);
                check($sformatf("%s.rst_timeout", name), timeout, 0);
                #4 reset_n = 1'b1;
                return;
            end
            core_done = (r < fin) ? sched[r] : 4'b0000;
            if (r == toggle_at) start_process = 1'b0;
            if (r == toggle_at + 1) start_process = 1'b1;
        end
        for (int h = 0; h < hold_n; h++) begin
            step();
            core_done = 4'($urandom_range(0, 15));
            check($sformatf("%s.hold_status@%0d", name, h), status, 3);
            check($sformatf("%s.hold_count@%0d", name, h), cycle_count, fin);
            check($sformatf("%s.hold_timeout@%0d", name, h), timeout, to);
            check($sformatf("%s.hold_core_start@%0d", name, h), core_start, 0);
        end
        core_done     = 4'b0000;
        start_process = 1'b0;
        step();
        check($sformatf("%s.idle_status", name), status, 0);
        check($sformatf("%s.idle_count", name), cycle_count, fin);
        check($sformatf("%s.idle_timeout", name), timeout, to);
        step();
        check($sformatf("%s.idle2_status", name), status, 0);
        check($sformatf("%s.idle2_core_start", name), core_start, 0);
    endtask

    initial begin
        int fin;
        bit to;
        int tog;
        reset_n       = 1'b0;
        start_process = 1'b0;
        core_done     = 4'b0000;
        start_sat     = 1'b0;
        done_sat      = 4'b0000;
        #1;
        check("reset.status", status, 0);
        check("reset.core_start", core_start, 0);
        check("reset.count", cycle_count, 0);
        check("reset.timeout", timeout, 0);
        repeat (3) step();
        check("reset3.status", status, 0);
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            check($sformatf("quiet.status@%0d", c), status, 0);
            check($sformatf("quiet.core_start@%0d", c), core_start, 0);
            check($sformatf("quiet.count@%0d", c), cycle_count, 0);
        end

        // each core done five cycles after its own launch
        clear_sched();
        for (int i = 0; i < 4; i++) sched[i + 5][i] = 1'b1;
        do_run("basic", -1, 8, -1);

        // all dones during the first launch cycle: only core 0 may count
        clear_sched();
        sched[0] = 4'b1111;
        sched[6] = 4'b0010;
        sched[7] = 4'b0100;
        sched[8] = 4'b1000;
        do_run("early", -1, 2, -1);

        // core 2 never reports: timeout after T cycles
        clear_sched();
        sched[5] = 4'b1011;
        do_run("tmo", -1, 3, -1);

        // start toggled low-high mid-run, held high in FINISHED
        clear_sched();
        for (int i = 0; i < 4; i++) sched[i + 8][i] = 1'b1;
        do_run("toggle", 6, 8, -1);

        // reset pulse mid-run with start held, then restart from the held level
        clear_sched();
        for (int i = 0; i < 4; i++) sched[i + 10][i] = 1'b1;
        do_run("abort", -1, 0, 6);
        clear_sched();
        for (int i = 0; i < 4; i++) sched[i + 5][i] = 1'b1;
        do_run("restart", -1, 1, -1);

        for (int k = 0; k < 6; k++) begin
            for (int r = 0; r < SCHED_N; r++)
                sched[r] = 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                int j;
                j = int'($urandom_range(0, 3));
                for (int r = 0; r < SCHED_N; r++) sched[r][j] = 1'b0;
            end
            model(fin, to);
            tog = (fin >= 7) ? int'($urandom_range(4, fin - 2)) : -1;
            do_run($sformatf("rnd%0d", k), tog, int'($urandom_range(0, 8)), -1);
        end

        // narrow counter saturates at 7 instead of wrapping
        start_sat = 1'b1;
        step();
        step();
        for (int r = 0; r <= 9; r++) begin
            check($sformatf("sat.status@%0d", r), status_sat, (r == 9) ? 3 : ((r < 4) ? 1 : 2));
            check($sformatf("sat.count@%0d", r), count_sat, (r < 7) ? r : 7);
            done_sat = (r >= 5 && r < 9) ? 4'(1 << (r - 5)) : 4'b0000;
            if (r < 9) step();
        end
        check("sat.timeout", timeout_sat, 0);
        done_sat  = 4'b0000;
        start_sat = 1'b0;
        step();
        check("sat.idle_status", status_sat, 0);
        check("sat.idle_count", count_sat, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/core_launch_sequencer.md
CORE_LAUNCH_SEQUENCER -- requirements
Module: core_launch_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd5000: run-phase cycle limit before the run is aborted.
REQ-002 Parameter COUNT_W, default 16: width of cycle_count.
REQ-003 fast_clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start_process  input  1  level request from the host; a run begins on its rising edge.
REQ-006 core_done  input  4  per-core completion pulse or level, bit i = core i.
REQ-007 core_start  output  4  one-cycle launch pulse, bit i = core i.
REQ-008 status  output  2  encoding: 0 IDLE, 1 LAUNCH, 2 RUNNING, 3 FINISHED.
REQ-009 timeout  output  1  sticky flag, high when FINISHED was reached by timeout.
REQ-010 cycle_count  output  COUNT_W  number of cycles spent in LAUNCH plus RUNNING for the current or last run.

Function
REQ-011 The block SHALL register start_process once and detect a rising edge as start_q==1 and start_prev==0.
REQ-012 The FSM SHALL have exactly four states, IDLE, LAUNCH, RUNNING and FINISHED, and status SHALL equal the state encoding, registered.
REQ-013 From IDLE, the FSM SHALL enter LAUNCH on a detected rising edge; it SHALL clear done_mask, timeout and cycle_count in the same cycle.
REQ-014 In LAUNCH, the block SHALL pulse core_start[k] for exactly one cycle for k = 0,1,2,3 on consecutive cycles, taking 4 cycles in total, with at most one bit high per cycle.
REQ-015 After core_start[3] is pulsed, the FSM SHALL enter RUNNING on the next cycle.
REQ-016 The block SHALL OR core_done[i] into the sticky done_mask[i] only if core i has already been launched; a done on an unlaunched core SHALL be ignored.
REQ-017 In RUNNING, the FSM SHALL enter FINISHED in the cycle after done_mask becomes 4'b1111, including a mask completed by dones captured during LAUNCH.
REQ-018 In LAUNCH or RUNNING, if cycle_count reaches TIMEOUT_CYCLES, the FSM SHALL enter FINISHED and set timeout=1.
REQ-019 If completion and timeout occur in the same cycle, completion SHALL win and timeout SHALL stay 0.
REQ-020 cycle_count SHALL increment by 1 in every LAUNCH and RUNNING cycle and saturate at its all-ones value without wrapping.
REQ-021 cycle_count SHALL hold its value in FINISHED and IDLE until the next run starts.
REQ-022 FINISHED SHALL be held while start_process is high; when start_process is low, the FSM SHALL return to IDLE on the next cycle.
REQ-023 When start_process falls during LAUNCH or RUNNING, the run SHALL NOT be aborted.
REQ-024 A rising edge of start_process outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-025 In FINISHED, the FSM SHALL accept no new start until it has passed through IDLE, so a new run requires start_process low then high.
REQ-026 core_start SHALL be 4'b0000 in every state except LAUNCH.

Reset
REQ-027 Assertion of reset_n low SHALL immediately force state IDLE, status=0, core_start=0, done_mask=0, timeout=0, cycle_count=0 and start_prev=0, independent of fast_clock.
REQ-028 Reset asserted mid-run SHALL abandon the run without a FINISHED indication; after release, a start_process already held high SHALL be treated as a new rising edge on the second cycle.
REQ-029 Release of reset_n SHALL be treated as synchronous to fast_clock; no output SHALL glitch on release.

Verification
REQ-030 Hold reset_n low for 3 cycles, release, hold start_process=0 for 10 cycles -> status=0, core_start=0, cycle_count=0 throughout.
REQ-031 Raise start_process and hold it; each core raises its done 5 cycles after its own start pulse -> core_start goes 0001, 0010, 0100, 1000 on consecutive cycles; status goes 1 then 2 then 3; timeout=0; cycle_count=9.
REQ-032 With TIMEOUT_CYCLES=20, run with core 2 never done -> status=3 with timeout=1 and cycle_count=20; drop start_process -> status=0 on the next cycle.
REQ-033 Pulse core_done=4'b1111 during the first LAUNCH cycle -> only bit 0 is captured; FINISHED is reached only after cores 1-3 signal done again.
REQ-034 Pulse reset_n low for half a cycle during RUNNING with start_process held high -> outputs return to reset values at once, and a new LAUNCH begins 2 cycles after release.
REQ-035 Toggle start_process low then high during RUNNING, and hold it high in FINISHED for 8 cycles -> neither the run nor the status is disturbed; a second run starts only after a low-high toggle from IDLE.
